latch_exerciser: RTL and testbench

//  Synthesizable stimulus-and-check engine for level-sensitive latch DUTs.
//  - Drives the DUT's enable and data inputs with a fixed pattern.
//  - Keeps a cycle-accurate shadow latch model.
//  - Compares the DUT's q against the model after a settle delay, counts mismatches
//    and reports pass/fail.
//  - Lets latch and latch-like cells be checked on silicon/FPGA, without a simulator.

---
 rtl/latch_exerciser.sv | 171 +++++++++++++++++
 tb/tb_latch_exerciser.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_exerciser.sv
// latch_exerciser
//   Stimulus-and-check engine for level-sensitive latch DUTs. It drives the
//   DUT latch with a fixed enable/data pattern, keeps a shadow latch model and
//   compares the DUT's output against that model after a SETTLE-cycle delay.
//   The run result is reported as an error count, the step of the first error
//   and a pass flag.
//
// Ports
//   clk            in   1  clock, rising edge
//   rst_n          in   1  synchronous reset, active-low
//   start          in   1  begins a run when idle
//   q_i            in   W  DUT latch output (already synchronous to clk)
//   lat_en         out  1  DUT latch enable (transparent when 1)
//   lat_d          out  W  DUT latch data
//   busy           out  1  high while running or draining
//   done           out  1  one-cycle pulse at the end of a run
//   pass           out  1  last run had no mismatches; held until next start
//   err_count      out  8  mismatches in current/last run, saturating
//   first_err_step out  8  step count at first mismatch, 8'hFF if none
module latch_exerciser #(
  parameter int W           = 1,
  parameter int HALF_PERIOD = 10,
  parameter int D_STEP      = 3,
  parameter int NUM_STEPS   = 10,
  parameter int SETTLE      = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] q_i,
  output logic         lat_en,
  output logic [W-1:0] lat_d,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   err_count,
  output logic [7:0]   first_err_step
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t       state;
  logic [15:0]  ph_cnt;
  logic [15:0]  d_cnt;
  logic [15:0]  step_cnt;
  logic [3:0]   drain_cnt;
  logic [W-1:0] m_q;
  logic         model_known;
  logic         track;
  logic         clr;
  logic         cmp_v;
  logic [W-1:0] cmp_q;

  assign track = (state == RUN) || (state == DRAIN);
  assign clr   = (state == IDLE) && start;

  // Delay {model_known, m_q} by SETTLE cycles before comparing with q_i.
  generate
    if (SETTLE == 0) begin : g_nodly
      assign cmp_v = model_known;
      assign cmp_q = m_q;
    end else begin : g_dly
      localparam int PW = SETTLE * W;
      logic [SETTLE-1:0]        pv;
      logic [SETTLE-1:0][W-1:0] pd;

      always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
          pv <= '0;
          pd <= '0;
        end else if (track) begin
          pv <= (pv << 1) | SETTLE'(model_known);
          pd <= (pd << W) | PW'(m_q);
        end
      end

      assign cmp_v = pv[SETTLE-1];
      assign cmp_q = pd[SETTLE-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      lat_en         <= 1'b0;
      lat_d          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_step <= '1;
      ph_cnt         <= '0;
      d_cnt          <= '0;
      step_cnt       <= '0;
      drain_cnt      <= '0;
      m_q            <= '0;
      model_known    <= 1'b0;
    end else begin
      done <= 1'b0;

      // Shadow latch and compare operate on the registered drive values.
      if (track) begin
        if (lat_en) begin
          m_q         <= lat_d;
          model_known <= 1'b1;
        end
        if (cmp_v && (q_i != cmp_q)) begin
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          if (err_count == 8'h00) first_err_step <= step_cnt[7:0];
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state          <= RUN;
            busy           <= 1'b1;
            ph_cnt         <= '0;
            d_cnt          <= '0;
            step_cnt       <= '0;
            err_count      <= '0;
            first_err_step <= '1;
            pass           <= 1'b0;
            model_known    <= 1'b0;
            lat_en         <= 1'b0;
            lat_d          <= '0;
          end
        end

        RUN: begin
          if (ph_cnt == 16'(HALF_PERIOD - 1)) begin
            ph_cnt <= '0;
            lat_en <= ~lat_en;
          end else begin
            ph_cnt <= ph_cnt + 16'd1;
          end
          // Final data step also updates lat_d; outputs freeze afterwards.
          if (d_cnt == 16'(D_STEP - 1)) begin
            d_cnt    <= '0;
            lat_d    <= lat_d + W'(1);
            step_cnt <= step_cnt + 16'd1;
            if (step_cnt == 16'(NUM_STEPS - 1)) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end else begin
            d_cnt <= d_cnt + 16'd1;
          end
        end

        DRAIN: begin
          if (drain_cnt == 4'(SETTLE)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end

        DONE: begin
          pass  <= (err_count == 8'h00);
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_exerciser.sv
module tb_latch_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b;
  logic [0:0] q_a;
  logic [7:0] q_b;
  logic       lat_en_a, busy_a, done_a, pass_a;
  logic [0:0] lat_d_a;
  logic [7:0] err_a, first_a;
  logic       lat_en_b, busy_b, done_b, pass_b;
  logic [7:0] lat_d_b, err_b, first_b;

  latch_exerciser u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .q_i(q_a),
    .lat_en(lat_en_a), .lat_d(lat_d_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_err_step(first_a)
  );

  latch_exerciser #(.W(8), .NUM_STEPS(200)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .q_i(q_b),
    .lat_en(lat_en_b), .lat_d(lat_d_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_err_step(first_b)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int unsigned err;
    int unsigned first;
    int unsigned blen;
  } exp_t;

  // Reference: run cycle r counts from the first cycle in RUN. Enable and
  // data are plain functions of r; the model latch is what was latched in
  // earlier cycles; a compare at cycle r uses the model as of r-st.
  // mode 0 ideal latch, 1 stuck-at sv, 2 edge flop, 3 ideal with flips.
  function automatic exp_t model(input int unsigned w, input int unsigned hp,
                                 input int unsigned ds, input int unsigned ns,
                                 input int unsigned st, input int mode,
                                 input int unsigned sv, input bit fl[64]);
    exp_t e;
    int unsigned rr = ns * ds;
    int unsigned last = rr + st;
    int unsigned en[1024], d[1024], m[1024], fv[1024];
    bit km[1024];
    int unsigned cur = 0, fcur = 0, q, rc_;
    bit kn = 0, prev = 0;
    for (int unsigned r = 0; r <= last; r++) begin
      rc_   = (r < rr) ? r : rr;
      en[r] = (rc_ / hp) % 2;
      d[r]  = (rc_ / ds) % (1 << w);
    end
    for (int unsigned r = 0; r <= last; r++) begin
      m[r] = cur; km[r] = kn; fv[r] = fcur;
      if (en[r] != 0) begin cur = d[r]; kn = 1; end
      if (en[r] != 0 && !prev) fcur = d[r];
      prev = (en[r] != 0);
    end
    e.err = 0; e.first = 255; e.blen = last + 1;
    for (int unsigned r = st; r <= last; r++) begin
      if (km[r-st]) begin
        case (mode)
          1: q = sv;
          2: q = fv[r-st];
          3: q = m[r-st] ^ int'(fl[r % 64]);
          default: q = m[r-st];
        endcase
        if (q != m[r-st]) begin
          if (e.err == 0) e.first = ((r < rr) ? r : rr) / ds;
          if (e.err < 255) e.err++;
        end
      end
    end
    return e;
  endfunction

  // External "latch under test" for instance A, with one-cycle sync delay.
  int          mode_a = 0;
  logic        sv_a = 1'b0;
  bit          flip_a[64];
  bit          nofl[64];
  int unsigned rc = 0;
  logic        lt = 1'b0, ff = 1'b0, en_prev = 1'b0, qd = 1'b0;

  always @(posedge clk) begin
    rc      <= busy_a ? rc + 1 : 0;
    lt      <= lat_en_a ? lat_d_a[0] : lt;
    ff      <= (lat_en_a && !en_prev) ? lat_d_a[0] : ff;
    en_prev <= lat_en_a;
    qd      <= (mode_a == 2) ? ff : lt;
  end

  always_comb begin
    q_a = 1'b0;
    if (mode_a == 1) q_a = sv_a;
    else             q_a = qd ^ (busy_a & flip_a[rc % 64]);
  end

  assign q_b = 8'hA5;

  // Scoreboard monitor for instance A.
  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned busy_cnt = 0;
  int unsigned done_seen = 0;
  bit          pass_pend = 0;
  int unsigned pass_exp = 0;

  always @(negedge clk) begin
    if (pass_pend) begin
      chk("pass", int'(pass_a), pass_exp);
      pass_pend = 0;
    end
    if (done_a === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("err_count", err_a, mon_e.err);
        chk("first_err_step", first_a, mon_e.first);
        chk("busy_len", busy_cnt, mon_e.blen);
        pass_exp  = (mon_e.err == 0) ? 1 : 0;
        pass_pend = 1;
      end
      done_seen++;
    end
    if (busy_a === 1'b1) busy_cnt++;
    else                 busy_cnt = 0;
  end

  task automatic check_reset_a();
    chk("rst_lat_en", int'(lat_en_a), 0);
    chk("rst_lat_d", int'(lat_d_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pass", int'(pass_a), 0);
    chk("rst_err_count", err_a, 0);
    chk("rst_first_err_step", first_a, 255);
  endtask

  task automatic run_a(input bit extra_fixed, input bit extra_rand);
    int unsigned t = 0;
    int unsigned ds0 = done_seen;
    exp_q.push_back(model(1, 10, 3, 10, 1, mode_a, int'(sv_a), flip_a));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (done_seen == ds0 && t < 200) begin
      start_a = (extra_fixed && (t == 5 || t == 12)) ||
                (extra_rand && busy_a && ($urandom_range(0, 7) == 0));
      @(negedge clk);
      t++;
    end
    start_a = 1'b0;
    if (done_seen == ds0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d expected<200", t);
    end
    repeat (2 + $urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    exp_t eb;
    int unsigned t;
    int unsigned blen_b;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 64; i++) begin flip_a[i] = 0; nofl[i] = 0; end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_a();

    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 64; i++) flip_a[i] = 0;
      case (n)
        0: begin mode_a = 0; run_a(0, 0); end
        1: begin mode_a = 0; run_a(1, 0); end
        2: begin mode_a = 1; sv_a = 1'b0; run_a(0, 0); end
        3: begin mode_a = 2; run_a(0, 0); end
        default: begin
          mode_a = int'($urandom_range(0, 3));
          sv_a   = 1'($urandom_range(0, 1));
          if (mode_a == 3)
            for (int i = 0; i < 64; i++) flip_a[i] = ($urandom_range(0, 7) == 0);
          run_a(0, 1);
        end
      endcase
    end

    // Reset in the middle of a run, then a clean run.
    mode_a = 0;
    for (int i = 0; i < 64; i++) flip_a[i] = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_a();
    exp_q.delete();
    run_a(0, 0);

    // Wide instance with stuck input: error count must saturate.
    eb = model(8, 10, 3, 200, 1, 1, 165, nofl);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    t = 0; blen_b = 0;
    while (done_b !== 1'b1 && t < 2000) begin
      if (busy_b === 1'b1) blen_b++;
      @(negedge clk);
      t++;
    end
    if (done_b !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_b_timeout actual=%0d expected<2000", t);
    end else begin
      chk("b_err_count", err_b, eb.err);
      chk("b_err_saturated", err_b, 255);
      chk("b_first_err_step", first_b, eb.first);
      chk("b_busy_len", blen_b, eb.blen);
      @(negedge clk);
      chk("b_pass", int'(pass_b), (eb.err == 0) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
